// File: rtl/bitstream_decoder.sv
// Stochastic bitstream to binary decoder: counts ones over 2^N qualified samples.
// Define BITSTREAM_DECODER_BIPOLAR_EN for bipolar (2*ones-2^N) output encoding.
module bitstream_decoder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic         bit_in,
  input  logic         bit_valid,
  output logic         busy,
  output logic [N+1:0] value,
  output logic         value_valid,
  input  logic         value_ready
);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [N:0]   ones;
  logic [N-1:0] samples;
  logic [N:0]   ones_fin;
  logic [N+1:0] result;
  logic         hs;
  logic         clr;
  logic         take;
  logic         last;

  assign hs       = (state == DONE) && value_ready;
  assign take     = (state == COUNT) && !start && bit_valid;
  assign last     = take && (samples == {N{1'b1}});
  assign clr      = start && ((state != DONE) || hs);
  assign ones_fin = ones + (N+1)'(bit_in);

`ifdef BITSTREAM_DECODER_BIPOLAR_EN
  localparam logic [N+1:0] OFFS = (N+2)'(2**N);
  assign result = {ones_fin, 1'b0} - OFFS;
`else
  assign result = {1'b0, ones_fin};
`endif

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; start wins over the last sample and restarts the window
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = COUNT;
      COUNT:   if (start) state_nxt = COUNT;
               else if (last) state_nxt = DONE;
      DONE:    if (hs) state_nxt = start ? COUNT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Window counters: cleared on an accepted start, advanced per qualified sample
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ones    <= '0;
      samples <= '0;
    end else if (clr) begin
      ones    <= '0;
      samples <= '0;
    end else if (take) begin
      ones    <= ones_fin;
      samples <= samples + 1'b1;
    end
  end

  // Result register, loaded with the final bit included
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)    value <= '0;
    else if (last) value <= result;
  end

  assign busy        = (state == COUNT);
  assign value_valid = (state == DONE);

endmodule

// File: tb/tb_bitstream_decoder.sv
// Directed, table-driven bench for bitstream_decoder (N=8).
// Build with BITSTREAM_DECODER_BIPOLAR_EN to check the bipolar encoding.
module tb_bitstream_decoder;

  localparam int N = 8;
  localparam int W = 1 << N;

  logic         clk = 0;
  logic         n_rst = 0;
  logic         start = 0;
  logic         bit_in = 0;
  logic         bit_valid = 0;
  logic         busy;
  logic [N+1:0] value;
  logic         value_valid;
  logic         value_ready = 0;

  int checks = 0;
  int errors = 0;

  bitstream_decoder #(.N(N)) dut (
    .clk(clk),
    .n_rst(n_rst),
    .start(start),
    .bit_in(bit_in),
    .bit_valid(bit_valid),
    .busy(busy),
    .value(value),
    .value_valid(value_valid),
    .value_ready(value_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           pat;
    bit           gap;
    int           cyc;
    logic [N+1:0] exp;
  } vec_t;

  // expected decoded result per pattern (0 zeros, 1 ones, 2 alt, 3 ten ones)
`ifdef BITSTREAM_DECODER_BIPOLAR_EN
  localparam logic [N+1:0] E0 = 10'h300;
  localparam logic [N+1:0] E1 = 10'h100;
  localparam logic [N+1:0] E2 = 10'h000;
  localparam logic [N+1:0] E3 = 10'h314;
`else
  localparam logic [N+1:0] E0 = 10'd0;
  localparam logic [N+1:0] E1 = 10'd256;
  localparam logic [N+1:0] E2 = 10'd128;
  localparam logic [N+1:0] E3 = 10'd10;
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic pat_bit(input int pat, input int i);
    case (pat)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (i % 2) == 0;
      default: return i < 10;
    endcase
  endfunction

  task automatic do_start();
    @(negedge clk);
    start = 1;
    bit_valid = 0;
  endtask

  // feed n qualified samples; flags any early value_valid or busy drop
  task automatic feed(input int n, input int pat, input bit gap,
                      output int cyc, output int bad);
    int i;
    i = 0;
    cyc = 0;
    bad = 0;
    while (i < n) begin
      @(negedge clk);
      if (value_valid || !busy) bad++;
      start = 0;
      if (gap && (cyc % 3) == 2) begin
        bit_valid = 0;
        bit_in = 1;
      end else begin
        bit_valid = 1;
        bit_in = pat_bit(pat, i);
        i++;
      end
      cyc++;
    end
    @(negedge clk);
    bit_valid = 0;
    bit_in = 0;
  endtask

  task automatic finish_window(input string name, input logic [N+1:0] exp);
    chk({name, " valid"}, int'(value_valid), 1);
    chk({name, " value"}, int'(value), int'(exp));
    chk({name, " busy_low"}, int'(busy), 0);
    value_ready = 1;
    @(negedge clk);
    value_ready = 0;
    chk({name, " valid_fall"}, int'(value_valid), 0);
    chk({name, " value_hold"}, int'(value), int'(exp));
  endtask

  vec_t vecs[5];

  initial begin
    int cyc;
    int bad;
    int unstable;
    logic [N+1:0] held;

    vecs[0] = '{pat: 1, gap: 1'b0, cyc: 256, exp: E1};
    vecs[1] = '{pat: 0, gap: 1'b0, cyc: 256, exp: E0};
    vecs[2] = '{pat: 2, gap: 1'b1, cyc: 383, exp: E2};
    vecs[3] = '{pat: 2, gap: 1'b0, cyc: 256, exp: E2};
    vecs[4] = '{pat: 3, gap: 1'b1, cyc: 383, exp: E3};

    #12;
    chk("reset busy", int'(busy), 0);
    chk("reset valid", int'(value_valid), 0);
    chk("reset value", int'(value), 0);
    @(negedge clk);
    n_rst = 1;
    @(negedge clk);
    chk("idle busy", int'(busy), 0);

    for (int v = 0; v < 5; v++) begin
      do_start();
      feed(W, vecs[v].pat, vecs[v].gap, cyc, bad);
      chk($sformatf("vec%0d in_window", v), bad, 0);
      chk($sformatf("vec%0d latency", v), cyc, vecs[v].cyc);
      finish_window($sformatf("vec%0d", v), vecs[v].exp);
    end

    // abort at sample 100: only post-restart samples count
    do_start();
    feed(100, 1, 1'b0, cyc, bad);
    start = 1;
    bit_valid = 1;
    bit_in = 1;
    feed(W, 3, 1'b0, cyc, bad);
    chk("abort in_window", bad, 0);
    finish_window("abort", E3);

    // start together with the last sample restarts, no result
    do_start();
    feed(W - 1, 1, 1'b0, cyc, bad);
    start = 1;
    bit_valid = 1;
    bit_in = 1;
    feed(W, 0, 1'b0, cyc, bad);
    chk("last_start in_window", bad, 0);
    finish_window("last_start", E0);

    // backpressure: result held, starts dropped
    do_start();
    feed(W, 2, 1'b0, cyc, bad);
    held = value;
    chk("bp value", int'(held), int'(E2));
    unstable = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (value !== held || !value_valid || busy) unstable++;
      start = (c % 4) == 1;
    end
    @(negedge clk);
    if (value !== held || !value_valid || busy) unstable++;
    chk("bp stable", unstable, 0);
    value_ready = 1;
    start = 1;
    @(negedge clk);
    value_ready = 0;
    start = 0;
    chk("bp hs valid_fall", int'(value_valid), 0);
    chk("bp hs busy_rise", int'(busy), 1);
    feed(W, 1, 1'b0, cyc, bad);
    chk("bp restart latency", cyc, W);
    finish_window("bp restart", E1);

    // async reset at sample 200
    do_start();
    feed(200, 1, 1'b0, cyc, bad);
    #2;
    n_rst = 0;
    #1;
    chk("rst busy", int'(busy), 0);
    chk("rst valid", int'(value_valid), 0);
    chk("rst value", int'(value), 0);
    @(negedge clk);
    n_rst = 1;
    bad = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      bit_valid = 1;
      bit_in = 1;
      if (value_valid || busy) bad++;
    end
    bit_valid = 0;
    chk("rst no_result", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitstream_decoder.md
# bitstream_decoder

Converts a stochastic unipolar bitstream back to binary by counting ones over a fixed window of qualified samples. It sits directly downstream of `network_control`, consuming its output bitstream and producing the integer that the top level splits into decimal digits for the hex displays. A valid/ready handshake holds each result until the consumer takes it.

## Interface
- `N`, default 8, log2 of the window length; the window is 2^N qualified samples.
- `clk  in  1`  system clock; all state changes on its rising edge.
- `n_rst  in  1`  reset, asynchronous and active-low.
- `start  in  1`  single-cycle request to begin a new measurement window.
- `bit_in  in  1`  bitstream sample.
- `bit_valid  in  1`  qualifies `bit_in`; a sample is taken only on cycles where this is high.
- `busy  out  1`  high while a window is being counted.
- `value  out  N+2`  decoded result; the encoding is set under Configuration.
- `value_valid  out  1`  high while `value` holds an unconsumed result.
- `value_ready  in  1`  the consumer accepts `value` when both this and `value_valid` are high.

## Operation
- States: IDLE, COUNT, DONE.
- **IDLE**
  - `start` moves to COUNT.
  - On that transition, clear `ones` (N+1 bits) and `samples` (N bits).
- **COUNT**
  - On each cycle with `bit_valid` high:
    - `samples` increments.
    - `ones` increments by `bit_in`.
  - Cycles with `bit_valid` low change nothing.
  - Last sample: `bit_valid` high while `samples == 2^N-1`.
    - Latch `value` from `ones + bit_in`; this includes the final bit.
    - Move to DONE.
  - `start` in COUNT aborts the window. The counters clear and COUNT restarts; the sample on that cycle is discarded.
  - If `start` and the last sample arrive together, `start` wins (restart) and no result is produced.
- **DONE**
  - `value_valid` is high and `value` is stable.
  - Handshake (`value_valid && value_ready`) moves to IDLE.
  - Handshake in the same cycle as `start` moves straight to COUNT with the counters cleared.
  - `start` without `value_ready` is ignored; the request is dropped, not queued.
  - Samples are ignored.
- Arithmetic:
  - `ones` covers 0..2^N and cannot overflow.
  - `samples` wraps to 0 only at the window end; its value is irrelevant outside COUNT.
- Outputs:
  - `busy` is high exactly in COUNT.
  - `value_valid` is high exactly in DONE.
  - `value` holds its last latched result outside DONE.

## Timing
- Reset values: state IDLE, `busy=0`, `value_valid=0`, `value=0`, all counters 0.
- Assertion of `n_rst` low takes effect immediately, including mid-window or with a result pending in DONE. An aborted window produces no result.
- `busy` rises the cycle after `start` is sampled in IDLE.
- `value_valid` rises on the cycle after the last sample is sampled. With continuous `bit_valid`, `start` to `value_valid` takes 2^N+1 cycles.
- `value_valid` falls on the cycle after the handshake.
- Minimum throughput is one result per 2^N+2 cycles. If `value_ready` is tied high and `start` is re-issued on the handshake cycle, it is 2^N+1 cycles.
- All outputs are registered; no combinational path runs from any input to any output.

## Configuration
- Macro: `BITSTREAM_DECODER_BIPOLAR_EN`.
- **Defined:** the stream is bipolar.
  - `value = 2*ones_final - 2^N`, two's complement, N+2 bits.
  - Range is -2^N..+2^N.
- **Undefined:** the stream is unipolar.
  - `value = ones_final`, zero-extended to N+2 bits.
  - Range is 0..2^N.
- State machine, handshake and timing are identical in both builds.

## Test plan
- **Window endpoints (unipolar, N=8):**
  - `start`, then 256 cycles of `bit_in=1` with `bit_valid=1` -> `value=256`, `value_valid` high on cycle 257.
  - Same with `bit_in=0` -> `value=0`.
- **Alternating input (unipolar, N=8):** `bit_in` alternating 1,0 for 256 samples, `bit_valid` low every third cycle -> `value=128`. `busy` stays high until 256 qualified samples have been taken.
- **Backpressure:**
  - Hold `value_ready=0` for 20 cycles after `value_valid` -> `value` stable, further `start` pulses ignored.
  - Then raise `value_ready` together with `start` -> `value_valid` falls, `busy` rises on the next cycle.
- **Abort and reset:**
  - `start` at sample 100 -> window restarts and the result reflects only post-restart samples.
  - Separately, `n_rst` low at sample 200 -> immediate IDLE, all outputs 0, no `value_valid`.
- **Bipolar build (`BITSTREAM_DECODER_BIPOLAR_EN`):**
  - All-ones -> `value=+256`.
  - All-zeros -> `value=-256` (10'b1100000000).
  - Alternating -> `value=0`.
